// File: rtl/output_port_bank.sv
// output_port_bank: a bank of CHANNELS output latches loaded from the system bus.
// A scan multiplexer time-shares one digit bus across the latches and inserts
// one blank cycle at every digit change.
module output_port_bank #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int SCAN_DIV = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic [WIDTH-1:0]             bus_input,
    input  logic                         L_O_bar,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         blank,
    output logic [CHANNELS*WIDTH-1:0]    display_output,
    output logic [WIDTH-1:0]             scan_data,
    output logic [CHANNELS-1:0]          scan_enable_bar,
    output logic [CHANNELS-1:0]          updated
);

    localparam int                 PRE_W         = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0]   PRE_LAST      = PRE_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]   DIGIT_LAST    = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]     CHANNEL_COUNT = (SEL_W + 1)'(CHANNELS);

    logic [WIDTH-1:0]    latch_q [CHANNELS];
    logic [WIDTH-1:0]    latch_d [CHANNELS];
    logic [CHANNELS-1:0] updated_q;
    logic [CHANNELS-1:0] updated_d;
    logic [PRE_W-1:0]    prescaler_q;
    logic [PRE_W-1:0]    prescaler_d;
    logic [SEL_W-1:0]    digit_q;
    logic [SEL_W-1:0]    digit_d;
    logic                load_valid;
    logic                prescaler_wrap;

    // Decode the load strobe; a select beyond the last channel loads nothing.
    always_comb begin
        load_valid = !L_O_bar && ({1'b0, sel} < CHANNEL_COUNT);
        for (int i = 0; i < CHANNELS; i++) begin
            latch_d[i]   = latch_q[i];
            updated_d[i] = 1'b0;
            if (load_valid && (sel == SEL_W'(i))) begin
                latch_d[i]   = bus_input;
                updated_d[i] = 1'b1;
            end
        end
    end

    // Prescaler free-runs; the digit steps only when the prescaler wraps.
    always_comb begin
        prescaler_wrap = (prescaler_q == PRE_LAST);
        prescaler_d    = prescaler_wrap ? '0 : prescaler_q + 1'b1;
        digit_d        = digit_q;
        if (prescaler_wrap) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
    end

    // All state clears immediately on CLR so no partial load can survive.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < CHANNELS; i++) begin
                latch_q[i] <= '0;
            end
            updated_q   <= '0;
            prescaler_q <= '0;
            digit_q     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                latch_q[i] <= latch_d[i];
            end
            updated_q   <= updated_d;
            prescaler_q <= prescaler_d;
            digit_q     <= digit_d;
        end
    end

    // Scan outputs: prescaler==0 is the blanking cycle that hides the digit change.
    always_comb begin
        scan_data       = '0;
        scan_enable_bar = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (digit_q == SEL_W'(i)) begin
                scan_data = latch_q[i];
                if (!blank && (prescaler_q != '0)) begin
                    scan_enable_bar[i] = 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_display
        assign display_output[g*WIDTH +: WIDTH] = latch_q[g];
    end

    assign updated = updated_q;

endmodule

// File: tb/tb_output_port_bank.sv
// Self-checking bench for output_port_bank: a main instance (4 channels, scan
// divider 4) compared every cycle against a behavioural model, plus a 3-channel
// instance for the out-of-range select case.
module tb_output_port_bank;

    localparam int CH = 4;
    localparam int SD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        clr, lob, blank;
    logic [1:0]  sel;
    logic [7:0]  bus;
    logic [31:0] disp;
    logic [7:0]  sdata;
    logic [3:0]  sen, upd;

    // 3-channel instance signals
    logic        clr3, lob3, blank3;
    logic [1:0]  sel3;
    logic [7:0]  bus3;
    logic [23:0] disp3;
    logic [7:0]  sdata3;
    logic [2:0]  sen3, upd3;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    output_port_bank #(.WIDTH(8), .CHANNELS(CH), .SCAN_DIV(SD)) u_dut (
        .CLK(clk), .CLR(clr), .bus_input(bus), .L_O_bar(lob), .sel(sel),
        .blank(blank), .display_output(disp), .scan_data(sdata),
        .scan_enable_bar(sen), .updated(upd)
    );

    output_port_bank #(.WIDTH(8), .CHANNELS(3), .SCAN_DIV(2)) u_dut3 (
        .CLK(clk), .CLR(clr3), .bus_input(bus3), .L_O_bar(lob3), .sel(sel3),
        .blank(blank3), .display_output(disp3), .scan_data(sdata3),
        .scan_enable_bar(sen3), .updated(upd3)
    );

    // Behavioural model: latch contents, last-edge load pulse and the number
    // of edges since reset; scan position is derived arithmetically from it.
    int unsigned m_edges;
    logic [7:0]  m_latch [CH];
    logic [3:0]  m_upd;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_edges <= 0;
            m_upd   <= '0;
            for (int i = 0; i < CH; i++) m_latch[i] <= '0;
        end else begin
            m_upd <= '0;
            if (!lob && (int'(sel) < CH)) begin
                m_latch[sel] <= bus;
                m_upd[sel]   <= 1'b1;
            end
            m_edges <= m_edges + 1;
        end
    end

    function automatic int m_pres();
        return int'(m_edges % SD);
    endfunction

    function automatic int m_digit();
        return int'((m_edges / SD) % CH);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every falling edge, outputs versus the model.
    logic [31:0] exp_disp;
    logic [3:0]  exp_sen;
    always @(negedge clk) begin
        if (cmp_on) begin
            exp_disp = {m_latch[3], m_latch[2], m_latch[1], m_latch[0]};
            exp_sen  = (blank || m_pres() == 0) ? 4'hF : ~(4'b0001 << m_digit());
            checkOutput("model_display", 64'(disp), 64'(exp_disp));
            checkOutput("model_scan_data", 64'(sdata), 64'(m_latch[m_digit()]));
            checkOutput("model_scan_enable", 64'(sen), 64'(exp_sen));
            checkOutput("model_updated", 64'(upd), 64'(m_upd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic l, input logic [1:0] s, input logic [7:0] b);
        lob = l;
        sel = s;
        bus = b;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int blank_cycles;
    bit found;

    initial begin
        clr = 1'b1; lob = 1'b1; sel = 2'd0; bus = 8'h00; blank = 1'b0;
        clr3 = 1'b1; lob3 = 1'b1; sel3 = 2'd0; bus3 = 8'h00; blank3 = 1'b0;
        tick();
        tick();
        checkOutput("reset_display", 64'(disp), 64'h0);
        checkOutput("reset_scan_enable", 64'(sen), 64'hF);
        checkOutput("reset_updated", 64'(upd), 64'h0);
        checkOutput("reset_scan_data", 64'(sdata), 64'h0);

        // first edge after release lights digit 0
        clr = 1'b0; clr3 = 1'b0;
        tick();
        checkOutput("first_edge_enable", 64'(sen), 64'hE);
        cmp_on = 1'b1;

        // out-of-range select on the 3-channel instance
        lob3 = 1'b0; sel3 = 2'd2; bus3 = 8'h5A;
        tick();
        checkOutput("ch3_load_display", 64'(disp3), 64'h5A0000);
        checkOutput("ch3_load_updated", 64'(upd3), 64'h4);
        sel3 = 2'd3; bus3 = 8'hFF;
        tick();
        checkOutput("ch3_oor_display", 64'(disp3), 64'h5A0000);
        checkOutput("ch3_oor_updated", 64'(upd3), 64'h0);
        lob3 = 1'b1;

        // single load of channel 2
        applyStimulus(1'b0, 2'd2, 8'h32);
        checkOutput("single_load_ch2", 64'(disp[23:16]), 64'h32);
        checkOutput("single_load_display", 64'(disp), 64'h00320000);
        checkOutput("single_load_updated", 64'(upd), 64'h4);
        applyStimulus(1'b1, 2'd2, 8'h32);
        checkOutput("single_load_updated_clear", 64'(upd), 64'h0);

        // hold with strobe inactive, then load channel 0
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd1, 8'hD8);
        checkOutput("hold_display", 64'(disp), 64'h00320000);
        applyStimulus(1'b0, 2'd0, 8'hD8);
        checkOutput("hold_then_load_ch0", 64'(disp[7:0]), 64'hD8);

        // back-to-back loads keep the updated bit high
        applyStimulus(1'b0, 2'd3, 8'h01);
        applyStimulus(1'b0, 2'd3, 8'h02);
        checkOutput("back_to_back_updated", 64'(upd), 64'h8);

        // load all channels, then free-run the scanner
        applyStimulus(1'b0, 2'd0, 8'h11);
        applyStimulus(1'b0, 2'd1, 8'h22);
        applyStimulus(1'b0, 2'd2, 8'h33);
        applyStimulus(1'b0, 2'd3, 8'h44);
        checkOutput("scan_load_display", 64'(disp), 64'h44332211);
        lob = 1'b1;
        blank_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (sen == 4'hF) blank_cycles++;
        end
        checkOutput("scan_blank_cycles", 64'(blank_cycles), 64'd8);

        // load channel 1 while digit 1 is lit
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_pres() == 1 && m_digit() == 1) found = 1'b1;
            else tick();
        end
        checkOutput("wait_digit1_found", 64'(found), 64'h1);
        applyStimulus(1'b0, 2'd1, 8'hA5);
        checkOutput("simul_scan_data", 64'(sdata), 64'hA5);
        checkOutput("simul_scan_enable", 64'(sen), 64'hD);
        lob = 1'b1;

        // blank acts immediately and does not disturb scan timing
        blank = 1'b1;
        #1;
        checkOutput("blank_immediate", 64'(sen), 64'hF);
        for (int i = 0; i < 3; i++) tick();
        blank = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // CLR during an active load strobe aborts everything at once
        lob = 1'b0; sel = 2'd3; bus = 8'h77;
        #1;
        clr = 1'b1;
        #1;
        checkOutput("clr_async_display", 64'(disp), 64'h0);
        checkOutput("clr_async_enable", 64'(sen), 64'hF);
        checkOutput("clr_async_updated", 64'(upd), 64'h0);
        checkOutput("clr_async_scan_data", 64'(sdata), 64'h0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("clr_hold_display", 64'(disp), 64'h0);
        checkOutput("clr_hold_updated", 64'(upd), 64'h0);
        lob = 1'b1;
        #1;
        clr = 1'b0;
        tick();
        checkOutput("post_clr_enable", 64'(sen), 64'hE);
        checkOutput("post_clr_display", 64'(disp), 64'h0);
        tick();

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
